// File: rtl/exu_alu_adder_pipe_pkg.sv
// ---------------------------------------------------------------------------
// alu_adder_pkg
// Shared definitions for the pipelined ALU adder:
//   - op_idx_e   : bit positions of the one-hot op vector (ADD=0 .. MAXU=8)
//   - OP_W       : width of the one-hot op vector
//   - cmp_flags_t: the eq/lt/ltu compare flag bundle carried in stage registers
//   - sub_mode() : ops that run the carry chain as op1 + ~op2 + 1
//   - op_legal() : op vector is non-zero and one-hot
// ---------------------------------------------------------------------------
package alu_adder_pkg;

    localparam int OP_W = 9;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_SLT   = 4'd2,
        OP_SLTU  = 4'd3,
        OP_AUIPC = 4'd4,
        OP_MIN   = 4'd5,
        OP_MAX   = 4'd6,
        OP_MINU  = 4'd7,
        OP_MAXU  = 4'd8
    } op_idx_e;

    typedef struct packed {
        logic eq;
        logic lt;
        logic ltu;
    } cmp_flags_t;

    // Every compare-based op needs op1 - op2, so they all share subtract mode.
    function automatic logic sub_mode(input logic [OP_W-1:0] op);
        return op[OP_SUB] | op[OP_SLT] | op[OP_SLTU] | op[OP_MIN] |
               op[OP_MAX] | op[OP_MINU] | op[OP_MAXU];
    endfunction

    // x & (x - 1) clears the lowest set bit; zero afterwards means one-hot.
    function automatic logic op_legal(input logic [OP_W-1:0] op);
        logic [OP_W-1:0] low_cleared;
        low_cleared = op & (op - {{(OP_W-1){1'b0}}, 1'b1});
        return (op != '0) && (low_cleared == '0);
    endfunction

endpackage

// File: rtl/exu_alu_adder_pipe_if.sv
// ---------------------------------------------------------------------------
// exu_alu_adder_pipe_if
// Request/response bundle of the pipelined ALU adder.
//   Request : flush_i, in_valid_i, in_ready_o, op_i, op1_i, op2_i, tag_i
//   Response: out_valid_o, out_ready_i, result_o, eq_o, lt_o, ltu_o, tag_o
// Modports: slave = the adder, master = whoever drives it (dispatch / bench).
// ---------------------------------------------------------------------------
interface exu_alu_adder_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    import alu_adder_pkg::*;

    logic             flush_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [OP_W-1:0]  op_i;
    logic [XLEN-1:0]  op1_i;
    logic [XLEN-1:0]  op2_i;
    logic [TAG_W-1:0] tag_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [XLEN-1:0]  result_o;
    logic             eq_o;
    logic             lt_o;
    logic             ltu_o;
    logic [TAG_W-1:0] tag_o;

    modport slave (
        input  flush_i, in_valid_i, op_i, op1_i, op2_i, tag_i, out_ready_i,
        output in_ready_o, out_valid_o, result_o, eq_o, lt_o, ltu_o, tag_o
    );

    modport master (
        output flush_i, in_valid_i, op_i, op1_i, op2_i, tag_i, out_ready_i,
        input  in_ready_o, out_valid_o, result_o, eq_o, lt_o, ltu_o, tag_o
    );

endinterface

// File: rtl/exu_alu_adder_pipe_add_slice.sv
// ---------------------------------------------------------------------------
// exu_alu_add_slice
// One carry-chain segment plus one pipeline register with valid/ready.
// The W-bit add is combinational (sum_o/cout_o) so the parent can fold it,
// together with anything else, into the P-bit payload that this stage
// registers. That keeps every stage output a plain flop.
// Ports:
//   clk, rst, flush_i        clock, sync reset, kill valid at next edge
//   up_valid_i / up_ready_o  handshake with the stage above
//   a_i, b_i, cin_i          segment operands and carry-in
//   sum_o, cout_o            combinational segment sum and carry-out
//   data_i / data_o          payload in / registered payload out
//   valid_o / down_ready_i   handshake with the stage below
// ---------------------------------------------------------------------------
module exu_alu_add_slice #(
    parameter int W = 16,
    parameter int P = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic         up_valid_i,
    output logic         up_ready_o,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o,
    input  logic [P-1:0] data_i,
    output logic         valid_o,
    input  logic         down_ready_i,
    output logic [P-1:0] data_o
);

    logic         valid_d;
    logic         valid_q;
    logic [P-1:0] data_d;
    logic [P-1:0] data_q;

    always_comb begin
        {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};
    end

    assign up_ready_o = !valid_q || down_ready_i;

    // Flush only drops the valid bit; the payload may load the doomed
    // transaction, which is harmless because nothing downstream will see it.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (up_ready_o) begin
            valid_d = up_valid_i;
        end
        if (up_valid_i && up_ready_o) begin
            data_d = data_i;
        end
        if (flush_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/exu_alu_adder_pipe.sv
// ---------------------------------------------------------------------------
// exu_alu_adder_pipe
// Pipelined ALU adder: ADD, SUB, SLT, SLTU, AUIPC, MIN, MAX, MINU, MAXU.
// STAGES=1 runs the full carry chain in one stage; STAGES=2 splits it at
// XLEN/2, registering the low half and its carry-out in stage 0. The compare
// flags and result mux are evaluated in front of the last register so every
// output comes straight from a flop.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   bus       exu_alu_adder_pipe_if.slave (request/response handshake)
// ---------------------------------------------------------------------------
module exu_alu_adder_pipe
    import alu_adder_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STAGES = 1,
    parameter int TAG_W  = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    exu_alu_adder_pipe_if.slave         bus
);

    localparam int HALF = XLEN / 2;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  result;
        cmp_flags_t       flags;
    } out_t;

    // Stage-0 register of the split pipeline. Full operands are kept because
    // min/max must return a whole operand and eq compares all bits.
    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [OP_W-1:0]  op;
        logic [XLEN-1:0]  op1;
        logic [XLEN-1:0]  op2;
        logic [HALF-1:0]  sum_lo;
        logic             carry;
    } mid_t;

    localparam int OUT_W = $bits(out_t);
    localparam int MID_W = $bits(mid_t);

    // Final compare and result selection from the complete XLEN+1 bit sum.
    // Flags stay 0 outside subtract mode and for illegal op vectors.
    function automatic out_t finish_op(
        input logic [OP_W-1:0]  op,
        input logic [XLEN-1:0]  a,
        input logic [XLEN-1:0]  b,
        input logic [XLEN:0]    s,
        input logic [TAG_W-1:0] tag
    );
        out_t r;
        logic legal;
        logic eq;
        logic lt;
        logic ltu;
        r     = '0;
        r.tag = tag;
        legal = op_legal(op);
        eq    = (a == b);
        ltu   = ~s[XLEN];
        lt    = (a[XLEN-1] != b[XLEN-1]) ? a[XLEN-1] : s[XLEN-1];
        if (legal && sub_mode(op)) begin
            r.flags = '{eq: eq, lt: lt, ltu: ltu};
        end
        if (legal) begin
            if (op[OP_ADD] || op[OP_SUB] || op[OP_AUIPC]) begin
                r.result = s[XLEN-1:0];
            end else if (op[OP_SLT]) begin
                r.result = {{(XLEN-1){1'b0}}, lt};
            end else if (op[OP_SLTU]) begin
                r.result = {{(XLEN-1){1'b0}}, ltu};
            end else if (op[OP_MIN]) begin
                r.result = lt ? a : b;
            end else if (op[OP_MAX]) begin
                r.result = lt ? b : a;
            end else if (op[OP_MINU]) begin
                r.result = ltu ? a : b;
            end else begin
                r.result = ltu ? b : a;
            end
        end
        return r;
    endfunction

    out_t out_q;

    if (STAGES == 1) begin : g_one_stage
        logic            sub0;
        logic [XLEN-1:0] b_x;
        logic [XLEN-1:0] sum;
        logic            cout;
        out_t            fin_d;

        always_comb begin
            sub0  = sub_mode(bus.op_i);
            b_x   = sub0 ? ~bus.op2_i : bus.op2_i;
            fin_d = finish_op(bus.op_i, bus.op1_i, bus.op2_i, {cout, sum}, bus.tag_i);
        end

        exu_alu_add_slice #(.W(XLEN), .P(OUT_W)) u_slice0 (
            .clk          (clk),
            .rst          (rst),
            .flush_i      (bus.flush_i),
            .up_valid_i   (bus.in_valid_i),
            .up_ready_o   (bus.in_ready_o),
            .a_i          (bus.op1_i),
            .b_i          (b_x),
            .cin_i        (sub0),
            .sum_o        (sum),
            .cout_o       (cout),
            .data_i       (fin_d),
            .valid_o      (bus.out_valid_o),
            .down_ready_i (bus.out_ready_i),
            .data_o       (out_q)
        );
    end else begin : g_two_stage
        logic            sub0;
        logic [HALF-1:0] b0_x;
        logic [HALF-1:0] sum_lo;
        logic            cout_lo;
        mid_t            mid_d;
        mid_t            mid_q;
        logic            valid0;
        logic            ready1;
        logic            sub1;
        logic [HALF-1:0] b1_x;
        logic [HALF-1:0] sum_hi;
        logic            cout_hi;
        out_t            fin_d;

        // Stage 0: low half with the subtract carry-in; its carry-out is
        // the carry-in of the upper half one cycle later.
        always_comb begin
            sub0  = sub_mode(bus.op_i);
            b0_x  = sub0 ? ~bus.op2_i[HALF-1:0] : bus.op2_i[HALF-1:0];
            mid_d = '{tag: bus.tag_i, op: bus.op_i, op1: bus.op1_i, op2: bus.op2_i,
                      sum_lo: sum_lo, carry: cout_lo};
        end

        exu_alu_add_slice #(.W(HALF), .P(MID_W)) u_slice0 (
            .clk          (clk),
            .rst          (rst),
            .flush_i      (bus.flush_i),
            .up_valid_i   (bus.in_valid_i),
            .up_ready_o   (bus.in_ready_o),
            .a_i          (bus.op1_i[HALF-1:0]),
            .b_i          (b0_x),
            .cin_i        (sub0),
            .sum_o        (sum_lo),
            .cout_o       (cout_lo),
            .data_i       (mid_d),
            .valid_o      (valid0),
            .down_ready_i (ready1),
            .data_o       (mid_q)
        );

        // Stage 1: upper half from the registered carry, then flags and mux.
        always_comb begin
            sub1  = sub_mode(mid_q.op);
            b1_x  = sub1 ? ~mid_q.op2[XLEN-1:HALF] : mid_q.op2[XLEN-1:HALF];
            fin_d = finish_op(mid_q.op, mid_q.op1, mid_q.op2,
                              {cout_hi, sum_hi, mid_q.sum_lo}, mid_q.tag);
        end

        exu_alu_add_slice #(.W(HALF), .P(OUT_W)) u_slice1 (
            .clk          (clk),
            .rst          (rst),
            .flush_i      (bus.flush_i),
            .up_valid_i   (valid0),
            .up_ready_o   (ready1),
            .a_i          (mid_q.op1[XLEN-1:HALF]),
            .b_i          (b1_x),
            .cin_i        (mid_q.carry),
            .sum_o        (sum_hi),
            .cout_o       (cout_hi),
            .data_i       (fin_d),
            .valid_o      (bus.out_valid_o),
            .down_ready_i (bus.out_ready_i),
            .data_o       (out_q)
        );
    end

    assign bus.result_o = out_q.result;
    assign bus.eq_o     = out_q.flags.eq;
    assign bus.lt_o     = out_q.flags.lt;
    assign bus.ltu_o    = out_q.flags.ltu;
    assign bus.tag_o    = out_q.tag;

endmodule

// File: tb/tb_exu_alu_adder_pipe.sv
// ---------------------------------------------------------------------------
// tb_exu_alu_adder_pipe
// Drives a STAGES=1 and a STAGES=2 instance of exu_alu_adder_pipe with
// directed vectors whose expected results were worked out by hand.
// Both instances share operands, flush and out_ready; in_valid is separate
// so the backpressure sequence can target the two-stage pipe alone.
// ---------------------------------------------------------------------------
module tb_exu_alu_adder_pipe;

    localparam logic [8:0] ADD   = 9'h001;
    localparam logic [8:0] SUB   = 9'h002;
    localparam logic [8:0] SLT   = 9'h004;
    localparam logic [8:0] SLTU  = 9'h008;
    localparam logic [8:0] AUIPC = 9'h010;
    localparam logic [8:0] MIN   = 9'h020;
    localparam logic [8:0] MAX   = 9'h040;
    localparam logic [8:0] MINU  = 9'h080;
    localparam logic [8:0] MAXU  = 9'h100;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid1;
    logic        in_valid2;
    logic        out_ready;
    logic [8:0]  op;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  tag;

    int total;
    int bad;

    exu_alu_adder_pipe_if #(.XLEN(32), .TAG_W(5)) if1 ();
    exu_alu_adder_pipe_if #(.XLEN(32), .TAG_W(5)) if2 ();

    assign if1.flush_i     = flush;
    assign if1.in_valid_i  = in_valid1;
    assign if1.op_i        = op;
    assign if1.op1_i       = op1;
    assign if1.op2_i       = op2;
    assign if1.tag_i       = tag;
    assign if1.out_ready_i = out_ready;

    assign if2.flush_i     = flush;
    assign if2.in_valid_i  = in_valid2;
    assign if2.op_i        = op;
    assign if2.op1_i       = op1;
    assign if2.op2_i       = op2;
    assign if2.tag_i       = tag;
    assign if2.out_ready_i = out_ready;

    exu_alu_adder_pipe #(.XLEN(32), .STAGES(1), .TAG_W(5)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    exu_alu_adder_pipe #(.XLEN(32), .STAGES(2), .TAG_W(5)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (if2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Both pipes empty, nothing valid, all data outputs zero, ready high.
    task automatic checkIdle(input string name);
        checkOutput({name, "/v1"},   {31'd0, if1.out_valid_o}, 32'd0);
        checkOutput({name, "/rdy1"}, {31'd0, if1.in_ready_o}, 32'd1);
        checkOutput({name, "/res1"}, if1.result_o, 32'd0);
        checkOutput({name, "/tag1"}, {27'd0, if1.tag_o}, 32'd0);
        checkOutput({name, "/flg1"}, {29'd0, if1.eq_o, if1.lt_o, if1.ltu_o}, 32'd0);
        checkOutput({name, "/v2"},   {31'd0, if2.out_valid_o}, 32'd0);
        checkOutput({name, "/rdy2"}, {31'd0, if2.in_ready_o}, 32'd1);
        checkOutput({name, "/res2"}, if2.result_o, 32'd0);
        checkOutput({name, "/tag2"}, {27'd0, if2.tag_o}, 32'd0);
        checkOutput({name, "/flg2"}, {29'd0, if2.eq_o, if2.lt_o, if2.ltu_o}, 32'd0);
    endtask

    // Issues one op to both pipes with out_ready high and checks that it
    // appears exactly 1 cycle (STAGES=1) and 2 cycles (STAGES=2) after the
    // accept edge, each for a single cycle. expFlags is {eq, lt, ltu}.
    task automatic applyStimulus(input string name, input logic [8:0] o,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] t, input logic [31:0] expRes,
                                 input logic [2:0] expFlags);
        @(posedge clk);
        #1;
        in_valid1 = 1'b1;
        in_valid2 = 1'b1;
        op  = o;
        op1 = a;
        op2 = b;
        tag = t;
        @(negedge clk);
        checkOutput({name, "/rdy1"}, {31'd0, if1.in_ready_o}, 32'd1);
        checkOutput({name, "/rdy2"}, {31'd0, if2.in_ready_o}, 32'd1);
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        in_valid2 = 1'b0;
        @(negedge clk);
        checkOutput({name, "/s1.v"},   {31'd0, if1.out_valid_o}, 32'd1);
        checkOutput({name, "/s1.res"}, if1.result_o, expRes);
        checkOutput({name, "/s1.flg"}, {29'd0, if1.eq_o, if1.lt_o, if1.ltu_o}, {29'd0, expFlags});
        checkOutput({name, "/s1.tag"}, {27'd0, if1.tag_o}, {27'd0, t});
        checkOutput({name, "/s2.early"}, {31'd0, if2.out_valid_o}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput({name, "/s2.v"},   {31'd0, if2.out_valid_o}, 32'd1);
        checkOutput({name, "/s2.res"}, if2.result_o, expRes);
        checkOutput({name, "/s2.flg"}, {29'd0, if2.eq_o, if2.lt_o, if2.ltu_o}, {29'd0, expFlags});
        checkOutput({name, "/s2.tag"}, {27'd0, if2.tag_o}, {27'd0, t});
        checkOutput({name, "/s1.gone"}, {31'd0, if1.out_valid_o}, 32'd0);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid1 = 1'b0;
        in_valid2 = 1'b0;
        out_ready = 1'b1;
        op        = '0;
        op1       = '0;
        op2       = '0;
        tag       = '0;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkIdle("reset");

        // Arithmetic, compare and min/max vectors. Flags are {eq, lt, ltu}.
        applyStimulus("add_wrap", ADD,   32'hFFFF_FFFF, 32'h0000_0001, 5'd3, 32'h0000_0000, 3'b000);
        applyStimulus("slt",      SLT,   32'h8000_0000, 32'h0000_0001, 5'd4, 32'h0000_0001, 3'b010);
        applyStimulus("sltu",     SLTU,  32'h8000_0000, 32'h0000_0001, 5'd5, 32'h0000_0000, 3'b010);
        applyStimulus("sub_eq",   SUB,   32'h0000_0005, 32'h0000_0005, 5'd6, 32'h0000_0000, 3'b100);
        applyStimulus("sub_neg",  SUB,   32'h0000_0003, 32'h0000_0005, 5'd8, 32'hFFFF_FFFE, 3'b011);
        applyStimulus("add_half", ADD,   32'h0000_FFFF, 32'h0000_0001, 5'd10, 32'h0001_0000, 3'b000);
        applyStimulus("auipc",    AUIPC, 32'h8000_0000, 32'h0000_1000, 5'd11, 32'h8000_1000, 3'b000);
        applyStimulus("minu",     MINU,  32'hFFFF_FFFE, 32'h0000_0002, 5'd12, 32'h0000_0002, 3'b010);
        applyStimulus("maxu",     MAXU,  32'hFFFF_FFFE, 32'h0000_0002, 5'd13, 32'hFFFF_FFFE, 3'b010);
        applyStimulus("max",      MAX,   32'hFFFF_FFFE, 32'h0000_0002, 5'd14, 32'h0000_0002, 3'b010);
        applyStimulus("min",      MIN,   32'hFFFF_FFFE, 32'h0000_0002, 5'd15, 32'hFFFF_FFFE, 3'b010);
        applyStimulus("min_eq",   MIN,   32'h0000_0007, 32'h0000_0007, 5'd16, 32'h0000_0007, 3'b100);
        applyStimulus("op_zero",  9'h000, 32'h0000_0005, 32'h0000_0003, 5'd7, 32'h0000_0000, 3'b000);
        applyStimulus("op_multi", ADD | SUB, 32'h0000_0005, 32'h0000_0003, 5'd9, 32'h0000_0000, 3'b000);

        // Backpressure on the two-stage pipe: tags 1,2,3 back-to-back.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid2 = 1'b1;
        op  = ADD;
        op1 = 32'h0000_0100;
        op2 = 32'h0000_0001;
        tag = 5'd1;
        @(negedge clk);
        checkOutput("bp/rdy_empty", {31'd0, if2.in_ready_o}, 32'd1);
        @(posedge clk);
        #1;
        op1 = 32'h0000_0200;
        op2 = 32'h0000_0002;
        tag = 5'd2;
        @(posedge clk);
        #1;
        op1 = 32'h0000_0300;
        op2 = 32'h0000_0003;
        tag = 5'd3;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput($sformatf("bp/full_rdy%0d", i), {31'd0, if2.in_ready_o}, 32'd0);
            checkOutput($sformatf("bp/hold_v%0d", i),   {31'd0, if2.out_valid_o}, 32'd1);
            checkOutput($sformatf("bp/hold_tag%0d", i), {27'd0, if2.tag_o}, 32'd1);
            checkOutput($sformatf("bp/hold_res%0d", i), if2.result_o, 32'h0000_0101);
            @(posedge clk);
        end
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp/rdy_release", {31'd0, if2.in_ready_o}, 32'd1);
        checkOutput("bp/tag1",        {27'd0, if2.tag_o}, 32'd1);
        @(posedge clk);
        #1;
        in_valid2 = 1'b0;
        @(negedge clk);
        checkOutput("bp/v2",   {31'd0, if2.out_valid_o}, 32'd1);
        checkOutput("bp/tag2", {27'd0, if2.tag_o}, 32'd2);
        checkOutput("bp/res2", if2.result_o, 32'h0000_0202);
        @(posedge clk);
        @(negedge clk);
        checkOutput("bp/v3",   {31'd0, if2.out_valid_o}, 32'd1);
        checkOutput("bp/tag3", {27'd0, if2.tag_o}, 32'd3);
        checkOutput("bp/res3", if2.result_o, 32'h0000_0303);
        @(posedge clk);
        @(negedge clk);
        checkOutput("bp/drained", {31'd0, if2.out_valid_o}, 32'd0);

        // Flush with two transactions in the two-stage pipe plus a new offer
        // to both pipes in the flush cycle; nothing may come out afterwards.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid2 = 1'b1;
        op  = ADD;
        op1 = 32'h0000_0010;
        op2 = 32'h0000_0001;
        tag = 5'd20;
        @(posedge clk);
        #1;
        tag = 5'd21;
        @(posedge clk);
        #1;
        in_valid1 = 1'b1;
        tag       = 5'd22;
        flush     = 1'b1;
        @(negedge clk);
        checkOutput("flush/pre_v2", {31'd0, if2.out_valid_o}, 32'd1);
        @(posedge clk);
        #1;
        flush     = 1'b0;
        in_valid1 = 1'b0;
        in_valid2 = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("flush/v1",   {31'd0, if1.out_valid_o}, 32'd0);
        checkOutput("flush/v2",   {31'd0, if2.out_valid_o}, 32'd0);
        checkOutput("flush/rdy2", {31'd0, if2.in_ready_o}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        checkOutput("flush/v2_later", {31'd0, if2.out_valid_o}, 32'd0);
        applyStimulus("post_flush", SUB, 32'h0000_0010, 32'h0000_0001, 5'd23, 32'h0000_000F, 3'b000);

        // Reset in the middle of a transaction discards it everywhere.
        @(posedge clk);
        #1;
        in_valid1 = 1'b1;
        in_valid2 = 1'b1;
        op  = ADD;
        op1 = 32'h0000_1234;
        op2 = 32'h0000_0001;
        tag = 5'd5;
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        in_valid2 = 1'b0;
        @(negedge clk);
        checkOutput("rst/pre_v1", {31'd0, if1.out_valid_o}, 32'd1);
        checkOutput("rst/pre_res1", if1.result_o, 32'h0000_1235);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkIdle("mid_rst");
        @(posedge clk);
        @(negedge clk);
        checkOutput("mid_rst/v2_later", {31'd0, if2.out_valid_o}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
